sd_syncn: RTL and testbench
===========================

Name: sd_syncn

Overview:
Parametrised N-stage synchronizer bank for bringing asynchronous level signals into the clk domain.
- Generalises the fixed two-flop synchronizer:
  - configurable depth;
  - synchronous reset to a defined value;
  - optional per-bit stability (glitch) filter;
  - registered-output rise/fall/change pulses.
- Used at clock-domain boundaries for status bits, interrupt lines and slow control levels. Multi-bit buses that need coherence still use gray coding or a handshake.

Parameters:
- width, 1, number of independent bits synchronized.
- stages, 2, synchronizer flop depth; legal 2..4; other values are a compile-time error.
- rst_val, {width{1'b0}}, value loaded into every synchronizer flop, filter output and edge-history flop on reset.
- filt_cnt, 0, stability filter length in cycles; 0 = filter bypassed; legal 0..255.

Ports:
- clk, input, 1, destination clock; all state is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- sync_in, input, width, asynchronous input levels.
- sync_out, output, width, synchronized (and filtered) levels.
- sync_rise, output, width, one-cycle pulse per bit when sync_out goes 0->1.
- sync_fall, output, width, one-cycle pulse per bit when sync_out goes 1->0.
- sync_chg, output, 1, OR-reduction of (sync_rise | sync_fall).

Behaviour:
- Chain: hgff_r[0] <= sync_in; hgff_r[j] <= hgff_r[j-1] for j = 1..stages-1. The flops are hgff-prefixed so synthesis can substitute high-gain cells. Chain end s = hgff_r[stages-1].
- filt_cnt == 0: sync_out = s directly.
  - Latency: a value sampled at edge k is on sync_out after edge k+stages-1. That is stages edges inclusive.
- filt_cnt = F > 0: each bit has a counter cnt[i], $clog2(F+1) bits wide, plus a filtered register f[i]; sync_out = f.
  - If s[i] == f[i]: cnt[i] <= 0.
  - Else if cnt[i] == F-1: f[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Result: f[i] follows only after s[i] has differed from f[i] for F consecutive cycles. Latency is stages+F edges inclusive.
  - Any excursion of s[i] shorter than F cycles is fully suppressed, with no output pulse. A return to equality mid-count clears the counter.
  - The counter never wraps: it saturates by construction at F-1 followed by a clear.
- Edge detect: p[i] <= sync_out[i] every cycle.
  - sync_rise = sync_out & ~p; sync_fall = ~sync_out & p.
  - Each pulse is exactly one cycle, in the first cycle sync_out shows the new value.
  - All outputs are functions of registers only; no combinational path from sync_in.
- Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses, and sync_chg is a single one-cycle pulse.
- Reset (any time, including mid-filter-count):
  - hgff_r[*] = rst_val, f = rst_val, p = rst_val, cnt = 0.
  - In the cycle after reset: sync_out = rst_val and sync_rise = sync_fall = 0, sync_chg = 0.
  - The first post-reset transition is judged against rst_val. Reset held N cycles keeps all outputs at these values.
- sync_in toggling every cycle with filt_cnt > 0: sync_out holds its last stable value indefinitely.

Optional Feature:
Macro SD_SYNC_RANDOM_DELAY_EN. Simulation only; ignored when SYNTHESIS is defined.
- Defined:
  - Each bit has a DLY[i] flag.
  - When set, the value fed to hgff_r[1] is taken from an extra delay flop after hgff_r[0], adding one cycle of latency to that bit, to mimic metastability resolution.
  - DLY is re-randomised ($random) every 3 clk cycles.
  - The filter and edge logic are unchanged. Pulses still last one cycle, but latency per bit is stages or stages+1 (plus F).
  - Reset clears DLY and the extra flop to rst_val.
- Undefined: latency is deterministic as stated above; no extra flops exist.

Test Plan:
- width=1, stages=2, filt_cnt=0: reset 3 cycles, release, sync_in 0->1 before edge k -> sync_out=1 after edge k+1; sync_rise=1 for exactly that cycle; sync_chg=1 same cycle; no pulse in the first cycle after reset.
- width=4, stages=3, rst_val=4'hF: assert reset with sync_in=0 -> sync_out=4'hF, no pulses; after release sync_out -> 4'h0 three edges later with sync_fall=4'hF for one cycle, sync_chg single pulse.
- stages=2, filt_cnt=3: sync_in 0->1 held -> sync_out=1 after edge k+4, rise pulse once; 2-cycle high glitch on sync_in -> sync_out stays 0, no pulses.
- filt_cnt=3, sync_in toggling every cycle for 50 cycles -> sync_out constant, sync_chg never asserted.
- Reset mid-count: filt_cnt=5, sync_in goes high, reset asserted 2 cycles after chain end changes -> cnt cleared, sync_out=rst_val; after release, a full 5 cycles of stability is required before sync_out changes.
- SD_SYNC_RANDOM_DELAY_EN defined, 1000 random level changes spaced ≥10 cycles -> every change appears with latency stages or stages+1, exactly one edge pulse per change, values never lost.

Source files
------------

// File: rtl/sd_syncn.sv
// N-stage synchronizer bank with optional per-bit stability filter and registered edge pulses.
// Optional simulation-only latency jitter: define SD_SYNC_RANDOM_DELAY_EN (ignored under SYNTHESIS).
module sd_syncn #(
  parameter int unsigned       width    = 1,
  parameter int unsigned       stages   = 2,
  parameter logic [width-1:0]  rst_val  = '0,
  parameter int unsigned       filt_cnt = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] sync_in,
  output logic [width-1:0] sync_out,
  output logic [width-1:0] sync_rise,
  output logic [width-1:0] sync_fall,
  output logic             sync_chg
);

  if (stages < 2 || stages > 4) begin : gen_bad_stages
    $error("sd_syncn: stages must be in 2..4");
  end
  if (filt_cnt > 255) begin : gen_bad_filt
    $error("sd_syncn: filt_cnt must be in 0..255");
  end

  // hgff prefix lets synthesis swap in high-gain flops.
  logic [width-1:0] hgff_q [stages];
  logic [width-1:0] hgff_d [stages];
  logic [width-1:0] chain_feed;
  logic [width-1:0] chain_end;
  logic [width-1:0] filt_out;
  logic [width-1:0] p_q, p_d;

`ifdef SD_SYNC_RANDOM_DELAY_EN
`ifndef SYNTHESIS
  // Per-bit random extra cycle after the first flop, mimicking slow metastability resolution.
  logic [width-1:0] dly_q;
  logic [width-1:0] xtra_q;
  logic [1:0]       rnd_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q     <= '0;
      xtra_q    <= rst_val;
      rnd_cnt_q <= '0;
    end else begin
      xtra_q <= hgff_q[0];
      if (rnd_cnt_q == 2'd2) begin
        rnd_cnt_q <= '0;
        dly_q     <= width'($random);
      end else begin
        rnd_cnt_q <= rnd_cnt_q + 2'd1;
      end
    end
  end

  assign chain_feed = (dly_q & xtra_q) | (~dly_q & hgff_q[0]);
`else
  assign chain_feed = hgff_q[0];
`endif
`else
  assign chain_feed = hgff_q[0];
`endif

  always_comb begin
    hgff_d[0] = sync_in;
    hgff_d[1] = chain_feed;
    for (int j = 2; j < stages; j++) begin
      hgff_d[j] = hgff_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < stages; j++) begin
        hgff_q[j] <= rst_val;
      end
    end else begin
      for (int j = 0; j < stages; j++) begin
        hgff_q[j] <= hgff_d[j];
      end
    end
  end

  assign chain_end = hgff_q[stages-1];

  if (filt_cnt == 0) begin : gen_nofilt
    assign filt_out = chain_end;
  end else begin : gen_filt
    localparam int unsigned    CntW    = $clog2(filt_cnt + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(filt_cnt - 1);

    logic [CntW-1:0]  cnt_q [width];
    logic [CntW-1:0]  cnt_d [width];
    logic [width-1:0] f_q, f_d;

    // Output follows only after filt_cnt consecutive cycles of disagreement.
    always_comb begin
      f_d = f_q;
      for (int i = 0; i < width; i++) begin
        cnt_d[i] = cnt_q[i];
        if (chain_end[i] == f_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          f_d[i]   = chain_end[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        f_q <= rst_val;
        for (int i = 0; i < width; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        f_q <= f_d;
        for (int i = 0; i < width; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign filt_out = f_q;
  end

  always_comb begin
    p_d = filt_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= rst_val;
    end else begin
      p_q <= p_d;
    end
  end

  assign sync_out  = filt_out;
  assign sync_rise = filt_out & ~p_q;
  assign sync_fall = ~filt_out & p_q;
  assign sync_chg  = |(sync_rise | sync_fall);

endmodule

// File: tb/tb_sd_syncn.sv
// Directed bench for sd_syncn: four configurations sharing one clock, hand-computed expectations.
module tb_sd_syncn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: w1 s2 f0
  logic       rst_a, in_a, out_a, rise_a, fall_a, chg_a;
  // B: w4 s3 rst F f0
  logic       rst_b, chg_b;
  logic [3:0] in_b, out_b, rise_b, fall_b;
  // C: w1 s2 f3
  logic       rst_c, in_c, out_c, rise_c, fall_c, chg_c;
  // D: w1 s2 f5
  logic       rst_d, in_d, out_d, rise_d, fall_d, chg_d;

  sd_syncn #(.width(1), .stages(2), .rst_val(1'b0), .filt_cnt(0)) u_a (
    .clk(clk), .reset(rst_a), .sync_in(in_a), .sync_out(out_a),
    .sync_rise(rise_a), .sync_fall(fall_a), .sync_chg(chg_a)
  );
  sd_syncn #(.width(4), .stages(3), .rst_val(4'hF), .filt_cnt(0)) u_b (
    .clk(clk), .reset(rst_b), .sync_in(in_b), .sync_out(out_b),
    .sync_rise(rise_b), .sync_fall(fall_b), .sync_chg(chg_b)
  );
  sd_syncn #(.width(1), .stages(2), .rst_val(1'b0), .filt_cnt(3)) u_c (
    .clk(clk), .reset(rst_c), .sync_in(in_c), .sync_out(out_c),
    .sync_rise(rise_c), .sync_fall(fall_c), .sync_chg(chg_c)
  );
  sd_syncn #(.width(1), .stages(2), .rst_val(1'b0), .filt_cnt(5)) u_d (
    .clk(clk), .reset(rst_d), .sync_in(in_d), .sync_out(out_d),
    .sync_rise(rise_d), .sync_fall(fall_d), .sync_chg(chg_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int cnt_pulse;
  int cnt_bad;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    in_a = 1'b0; in_b = 4'h0; in_c = 1'b0; in_d = 1'b0;
    tick(3);
    chk("a_rst_out", 32'(out_a), 32'h0);
    chk("a_rst_chg", 32'(chg_a), 32'h0);
    chk("b_rst_out", 32'(out_b), 32'hF);
    chk("b_rst_pulse", 32'({rise_b, fall_b, 3'b0, chg_b}), 32'h0);

    // A: basic two-flop latency and one-cycle rise pulse
    rst_a = 1'b0;
    tick(1);
    chk("a_post_rst_rise", 32'(rise_a), 32'h0);
    in_a = 1'b1;
    tick(1);
    chk("a_lat_k", 32'(out_a), 32'h0);
    tick(1);
    chk("a_lat_k1_out", 32'(out_a), 32'h1);
    chk("a_lat_k1_rise", 32'(rise_a), 32'h1);
    chk("a_lat_k1_chg", 32'(chg_a), 32'h1);
    tick(1);
    chk("a_rise_once", 32'({rise_a, chg_a}), 32'h0);
    in_a = 1'b0;
    tick(2);
    chk("a_fall_out", 32'(out_a), 32'h0);
    chk("a_fall_pulse", 32'(fall_a), 32'h1);

    // B: reset value F, falls to 0 three edges after release
    rst_b = 1'b0;
    tick(2);
    chk("b_hold_out", 32'(out_b), 32'hF);
    chk("b_hold_fall", 32'(fall_b), 32'h0);
    tick(1);
    chk("b_rel_out", 32'(out_b), 32'h0);
    chk("b_rel_fall", 32'(fall_b), 32'hF);
    chk("b_rel_chg", 32'(chg_b), 32'h1);
    tick(1);
    chk("b_rel_chg_once", 32'({fall_b, chg_b}), 32'h0);
    in_b = 4'b0101;
    tick(3);
    chk("b_multi_rise", 32'(rise_b), 32'h5);
    chk("b_multi_chg", 32'(chg_b), 32'h1);
    tick(1);
    chk("b_multi_chg_once", 32'(chg_b), 32'h0);

    // C: filter of 3, latency stages+F = 5 edges
    rst_c = 1'b0;
    tick(1);
    in_c = 1'b1;
    tick(4);
    chk("c_filt_k3", 32'(out_c), 32'h0);
    tick(1);
    chk("c_filt_k4_out", 32'(out_c), 32'h1);
    chk("c_filt_k4_rise", 32'(rise_c), 32'h1);
    in_c = 1'b0;
    cnt_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (fall_c) cnt_pulse++;
    end
    chk("c_fall_out", 32'(out_c), 32'h0);
    chk("c_fall_once", 32'(cnt_pulse), 32'h1);

    // 2-cycle glitch is one short of the filter length
    in_c = 1'b1;
    tick(2);
    in_c = 1'b0;
    cnt_pulse = 0;
    cnt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (chg_c) cnt_pulse++;
      if (out_c) cnt_bad++;
    end
    chk("c_glitch_chg", 32'(cnt_pulse), 32'h0);
    chk("c_glitch_out", 32'(cnt_bad), 32'h0);

    cnt_pulse = 0;
    cnt_bad = 0;
    for (int i = 0; i < 50; i++) begin
      in_c = ~in_c;
      tick(1);
      if (chg_c) cnt_pulse++;
      if (out_c) cnt_bad++;
    end
    chk("c_toggle_chg", 32'(cnt_pulse), 32'h0);
    chk("c_toggle_out", 32'(cnt_bad), 32'h0);

    // D: reset mid-count must clear the filter counter
    rst_d = 1'b0;
    tick(1);
    in_d = 1'b1;
    tick(2);
    tick(2);
    chk("d_pre_rst", 32'(out_d), 32'h0);
    rst_d = 1'b1;
    tick(1);
    chk("d_rst_out", 32'(out_d), 32'h0);
    rst_d = 1'b0;
    tick(6);
    chk("d_still_low", 32'(out_d), 32'h0);
    chk("d_no_early_rise", 32'(rise_d), 32'h0);
    tick(1);
    chk("d_out", 32'(out_d), 32'h1);
    chk("d_rise", 32'(rise_d), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
